seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_hex7.sv | 11 +
 rtl/seg_scan_ctrl.sv | 118 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for seven-segment display drivers: hex glyphs and off levels.
package seg_pkg;

  // Active-high glyphs for 0..F, bit order g..a; index 15 is listed first.
  localparam logic [15:0][6:0] HEX_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF_HIGH = 8'h00;
  localparam logic [7:0] SEG_OFF_LOW  = 8'hFF;

  function automatic logic [7:0] seg_drive(input logic [7:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_hex7.sv
// Combinational hex nibble to active-high seven-segment pattern (g..a).
module seg_hex7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_PAT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with shadowed frame data, leading-zero
// blanking and per-slot duty dimming; SEG/AN are registered (1 cycle latency).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int DIV        = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0]       SLICE   = 32'(DIV / 16);
  localparam logic [7:0]        SEG_OFF = ACTIVE_LOW ? SEG_OFF_LOW : SEG_OFF_HIGH;
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic                tick;
  logic                last_digit;
  logic                frame_wrap;

  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_blz;
  logic                load_pend;

  logic [4*DIGITS-1:0] disp_data;
  logic [DIGITS-1:0]   disp_dp;
  logic                disp_blz;

  logic [3:0]          nib;
  logic                dp_bit;
  logic                blank;
  logic                zero_run;
  logic [6:0]          seg_raw;
  logic [31:0]         thresh;
  logic                on_time;
  logic                show;
  logic [DIGITS-1:0]   onehot;
  logic [7:0]          seg_nxt;
  logic [DIGITS-1:0]   an_nxt;

  assign tick       = (pcnt == PW'(DIV - 1));
  assign last_digit = (idx == IW'(DIGITS - 1));
  assign frame_wrap = tick && last_digit;

  // First cycle after reset shows the inputs being captured, not the cleared shadows.
  assign disp_data = load_pend ? data     : sh_data;
  assign disp_dp   = load_pend ? dp_mask  : sh_dp;
  assign disp_blz  = load_pend ? blank_lz : sh_blz;

  always_comb begin
    nib      = 4'h0;
    dp_bit   = 1'b0;
    blank    = 1'b0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_data[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib    = disp_data[4*i +: 4];
        dp_bit = disp_dp[i];
        blank  = disp_blz && (i > 0) && zero_run;
      end
    end
  end

  seg_hex7 u_hex (
    .nibble (nib),
    .seg    (seg_raw)
  );

  assign thresh  = ({28'd0, brightness} + 32'd1) * SLICE;
  assign on_time = (32'(pcnt) < thresh);
  assign show    = on_time && !blank;
  assign onehot  = DIGITS'(1) << idx;
  assign seg_nxt = show ? seg_drive({dp_bit, seg_raw}, ACTIVE_LOW) : SEG_OFF;
  assign an_nxt  = show ? (ACTIVE_LOW ? ~onehot : onehot) : AN_OFF;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt       <= '0;
      idx        <= '0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blz     <= 1'b0;
      load_pend  <= 1'b1;
      SEG        <= SEG_OFF;
      AN         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      load_pend  <= 1'b0;
      pcnt       <= tick ? '0 : pcnt + PW'(1);
      if (tick) begin
        idx <= last_digit ? '0 : idx + IW'(1);
      end
      if (load_pend || frame_wrap) begin
        sh_data <= data;
        sh_dp   <= dp_mask;
        sh_blz  <= blank_lz;
      end
      frame_done <= frame_wrap;
      SEG        <= seg_nxt;
      AN         <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=8, DIV=16, low-true outputs).
module tb_seg_scan_ctrl;

  localparam int DIGITS = 8;
  localparam int DIV    = 16;
  localparam int L      = DIV * DIGITS;

  localparam logic [7:0] LOWTAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .SEG        (SEG),
    .AN         (AN),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected {SEG, AN, frame_done} for the k-th edge since reset release.
  function automatic logic [16:0] expect_out(input int kk, input logic [31:0] d,
                                             input logic [7:0] dp, input logic bz,
                                             input logic [3:0] br);
    int dig;
    int p;
    logic [3:0] n;
    logic [31:0] upper;
    logic blank_e;
    logic active;
    logic [7:0] an_e;
    logic [7:0] seg_e;
    dig     = (kk / DIV) % DIGITS;
    p       = kk % DIV;
    n       = d[4*dig +: 4];
    upper   = d >> (4 * dig);
    blank_e = bz && (dig > 0) && (upper == 32'd0);
    active  = !blank_e && (p < (int'(br) + 1) * (DIV / 16));
    an_e    = active ? ~(8'd1 << dig) : 8'hFF;
    seg_e   = active ? (LOWTAB[n] & ~{dp[dig], 7'b0}) : 8'hFF;
    return {seg_e, an_e, (kk % L) == (L - 1)};
  endfunction

  int          k;
  logic [31:0] snap_d;
  logic [7:0]  snap_dp;
  logic        snap_bz;
  logic [16:0] exp_o;

  always @(posedge clk) begin
    if (!rst) begin
      k     <= 0;
      exp_o <= {8'hFF, 8'hFF, 1'b0};
    end else begin
      if (k == 0) begin
        exp_o   <= expect_out(0, data, dp_mask, blank_lz, brightness);
        snap_d  <= data;
        snap_dp <= dp_mask;
        snap_bz <= blank_lz;
      end else begin
        exp_o <= expect_out(k, snap_d, snap_dp, snap_bz, brightness);
      end
      if ((k % L) == (L - 1)) begin
        snap_d  <= data;
        snap_dp <= dp_mask;
        snap_bz <= blank_lz;
      end
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model SEG", 32'(SEG), 32'(exp_o[16:9]));
      chk("model AN", 32'(AN), 32'(exp_o[8:1]));
      chk("model frame_done", 32'(frame_done), 32'(exp_o[0]));
    end
  end

  task automatic restart();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int an_fe;
    int fd_cnt;
    int errs;
    int on0;
    int on3;
    int err_old;
    int err_new;

    rst        = 1'b0;
    data       = 32'hDEADBEEF;
    dp_mask    = 8'h5A;
    blank_lz   = 1'b1;
    brightness = 4'd7;
    @(posedge clk);
    armed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset SEG", 32'(SEG), 32'hFF);
    chk("reset AN", 32'(AN), 32'hFF);
    chk("reset frame_done", 32'(frame_done), 32'h0);

    // Scan order and frame pulse.
    data = 32'h76543210; dp_mask = 8'h00; blank_lz = 1'b0; brightness = 4'd15;
    rst = 1'b1;
    an_fe = 0; fd_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (c == 0)   begin chk("scan d0 AN", 32'(AN), 32'hFE); chk("scan d0 SEG", 32'(SEG), 32'hC0); end
      if (c == 80)  begin chk("scan d5 AN", 32'(AN), 32'hDF); chk("scan d5 SEG", 32'(SEG), 32'h92); end
      if (c == 112) chk("scan d7 AN", 32'(AN), 32'h7F);
      if (c == 127) chk("scan frame_done", 32'(frame_done), 32'h1);
      if (c < 128 && AN == 8'hFE) an_fe++;
      if (frame_done) fd_cnt++;
    end
    chk("scan d0 hold", 32'(an_fe), 32'd16);
    chk("frame_done count", 32'(fd_cnt), 32'd2);

    // Leading-zero blanking.
    data = 32'h00000120; blank_lz = 1'b1;
    restart();
    errs = 0;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (c == 0)  chk("blank d0 SEG", 32'(SEG), 32'hC0);
      if (c == 16) begin chk("blank d1 SEG", 32'(SEG), 32'hA4); chk("blank d1 AN", 32'(AN), 32'hFD); end
      if (c == 32) begin chk("blank d2 SEG", 32'(SEG), 32'hF9); chk("blank d2 AN", 32'(AN), 32'hFB); end
      if (c >= 48 && (AN != 8'hFF || SEG != 8'hFF)) errs++;
    end
    chk("blank d3-7 off cycles", 32'(errs), 32'd0);

    // Duty cycle and decimal point.
    data = 32'h0; blank_lz = 1'b0; brightness = 4'd3; dp_mask = 8'h01;
    restart();
    on0 = 0; on3 = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) chk("duty dp SEG", 32'(SEG), 32'h40);
      if (c == 4) chk("duty off AN", 32'(AN), 32'hFF);
      if (c < 16 && AN != 8'hFF) on0++;
      if (c >= 48 && AN != 8'hFF) on3++;
    end
    chk("duty slot0 on", 32'(on0), 32'd4);
    chk("duty slot3 on", 32'(on3), 32'd4);

    // No tearing: new data lands only at the frame boundary.
    data = 32'h11111111; dp_mask = 8'h00; brightness = 4'd15;
    restart();
    err_old = 0; err_new = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (c >= 48 && c < 128 && SEG != 8'hF9) err_old++;
      if (c >= 128 && SEG != 8'hA4) err_new++;
      if (c == 127) chk("tear frame_done", 32'(frame_done), 32'h1);
      if (c == 48) data = 32'h22222222;
    end
    chk("tear old frame", 32'(err_old), 32'd0);
    chk("tear new frame", 32'(err_new), 32'd0);

    // Mid-frame reset, then a brightness change inside a slot.
    data = 32'h11111111;
    restart();
    repeat (86) @(negedge clk);
    data = 32'h000000AB;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst SEG", 32'(SEG), 32'hFF);
    chk("midrst AN", 32'(AN), 32'hFF);
    chk("midrst frame_done", 32'(frame_done), 32'h0);
    rst = 1'b1;
    an_fe = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (c == 0)  begin chk("restart AN", 32'(AN), 32'hFE); chk("restart SEG", 32'(SEG), 32'h83); end
      if (c == 16) chk("restart d1 SEG", 32'(SEG), 32'h88);
      if (c == 21) chk("bright0 AN off", 32'(AN), 32'hFF);
      if (c == 32) begin chk("bright0 d2 AN", 32'(AN), 32'hFB); chk("bright0 d2 SEG", 32'(SEG), 32'hC0); end
      if (c == 33) chk("bright0 d2 off", 32'(AN), 32'hFF);
      if (c < 16 && AN == 8'hFE) an_fe++;
      if (c == 20) brightness = 4'd0;
    end
    chk("restart d0 hold", 32'(an_fe), 32'd16);

    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
